time_set_ctrl: RTL and testbench

- Front-panel controller upstream of the 24 h / 12 h clock cores.
- Debounces four raw push-buttons and runs a set-mode state machine.
- Drives the cores' set_time level and the single-cycle digit-increment pulses hour10, hour1, min10, min1, sec10, sec1.
- Provides field/blink indication so the display scan stage can flash the digit pair being edited.

---
 rtl/clk_set_pkg.sv | 39 +++
 rtl/time_set_ctrl_debounce.sv | 68 ++++++
 rtl/time_set_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_set_pkg.sv
// +----------------------------------------------------------------------+
// | clk_set_pkg                                                           |
// | Shared encodings and helpers for the time-set front-panel controller. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package clk_set_pkg;

   localparam logic [1:0] RUN     = 2'b00;
   localparam logic [1:0] SET_HR  = 2'b01;
   localparam logic [1:0] SET_MIN = 2'b10;
   localparam logic [1:0] SET_SEC = 2'b11;

   localparam logic [1:0] FIELD_NONE = 2'b00;
   localparam logic [1:0] FIELD_HR   = 2'b01;
   localparam logic [1:0] FIELD_MIN  = 2'b10;
   localparam logic [1:0] FIELD_SEC  = 2'b11;

   // Button slots in the debouncer bank, lowest index = highest priority
   localparam int BTN_MODE = 0;
   localparam int BTN_NEXT = 1;
   localparam int BTN_TENS = 2;
   localparam int BTN_ONES = 3;

   localparam int P_SEC1   = 0;
   localparam int P_SEC10  = 1;
   localparam int P_MIN1   = 2;
   localparam int P_MIN10  = 3;
   localparam int P_HOUR1  = 4;
   localparam int P_HOUR10 = 5;

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/time_set_ctrl_debounce.sv
// +----------------------------------------------------------------------+
// | btn_debounce                                                          |
// | 2-FF synchroniser, stability counter, debounced level, press pulse.   |
// | Level output exists only when AUTOREPEAT_EN is defined.               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module btn_debounce
   import clk_set_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
`ifdef AUTOREPEAT_EN
   output logic level,
`endif
   output logic press
);

   localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // stable_d flips only after the synced value has disagreed for DEBOUNCE_CYCLES cycles
   always_comb begin
      sync1_d  = btn_raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign press = stable_d & ~stable_q;
`ifdef AUTOREPEAT_EN
   assign level = stable_q;
`endif

endmodule

`default_nettype wire

// File: rtl/time_set_ctrl.sv
// +----------------------------------------------------------------------+
// | time_set_ctrl                                                         |
// | Button debounce, set-mode FSM and digit-increment pulse generation.   |
// | Optional hold-to-repeat enabled by macro AUTOREPEAT_EN.               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module time_set_ctrl
   import clk_set_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BLINK_BIT       = 25,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_RATE     = 10000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_next,
   input  logic       btn_tens,
   input  logic       btn_ones,
   output logic       set_time,
   output logic       hour10,
   output logic       hour1,
   output logic       min10,
   output logic       min1,
   output logic       sec10,
   output logic       sec1,
   output logic [1:0] field,
   output logic       blink
);

   logic [3:0]         raw_w;
   logic [3:0]         prs_w;
   logic [1:0]         state_q, state_d;
   logic               set_time_q, set_time_d;
   logic [1:0]         field_q, field_d;
   logic [5:0]         pulse_q, pulse_d;
   logic [BLINK_BIT:0] blink_q, blink_d;
   logic               ev_mode, ev_next, ev_tens, ev_ones;
   logic               inc_tens, inc_ones;

   assign raw_w = {btn_ones, btn_tens, btn_next, btn_mode};

`ifdef AUTOREPEAT_EN
   logic [3:0] lvl_w;
`endif

   for (genvar i = 0; i < 4; i++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk     (clk),
         .reset   (reset),
         .btn_raw (raw_w[i]),
`ifdef AUTOREPEAT_EN
         .level   (lvl_w[i]),
`endif
         .press   (prs_w[i])
      );
   end

   // Fixed-priority arbitration: lower-priority coincident presses are dropped
   assign ev_mode = prs_w[BTN_MODE];
   assign ev_next = prs_w[BTN_NEXT] & ~prs_w[BTN_MODE];
   assign ev_tens = prs_w[BTN_TENS] & ~prs_w[BTN_NEXT] & ~prs_w[BTN_MODE];
   assign ev_ones = prs_w[BTN_ONES] & ~prs_w[BTN_TENS] & ~prs_w[BTN_NEXT] & ~prs_w[BTN_MODE];

`ifdef AUTOREPEAT_EN
   localparam int            HW        = cnt_width(REPEAT_DELAY);
   localparam logic [HW-1:0] HOLD_FIRE = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] HOLD_RELD = HW'(REPEAT_DELAY - REPEAT_RATE);

   logic          hold_act_q, hold_act_d;
   logic          hold_key_q, hold_key_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          rep_fire;

   // hold_q counts cycles since the press event; reload keeps later repeats REPEAT_RATE apart
   always_comb begin
      hold_act_d = hold_act_q;
      hold_key_d = hold_key_q;
      hold_d     = hold_q;
      rep_fire   = 1'b0;
      if ((state_d != state_q) || (state_q == RUN)) begin
         hold_act_d = 1'b0;
         hold_d     = '0;
      end else if (ev_tens || ev_ones) begin
         hold_act_d = 1'b1;
         hold_key_d = ev_ones;
         hold_d     = HW'(1);
      end else if (hold_act_q && (hold_key_q ? lvl_w[BTN_ONES] : lvl_w[BTN_TENS])) begin
         if (hold_q == HOLD_FIRE) begin
            rep_fire = 1'b1;
            hold_d   = HOLD_RELD;
         end else begin
            hold_d = hold_q + 1'b1;
         end
      end else begin
         hold_act_d = 1'b0;
         hold_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_act_q <= 1'b0;
         hold_key_q <= 1'b0;
         hold_q     <= '0;
      end else begin
         hold_act_q <= hold_act_d;
         hold_key_q <= hold_key_d;
         hold_q     <= hold_d;
      end
   end

   assign inc_tens = ev_tens | (rep_fire & ~hold_key_q);
   assign inc_ones = ev_ones | (rep_fire &  hold_key_q);
`else
   assign inc_tens = ev_tens;
   assign inc_ones = ev_ones;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (ev_mode) begin
         state_d = (state_q == RUN) ? SET_HR : RUN;
      end else if (ev_next) begin
         case (state_q)
            SET_HR:  state_d = SET_MIN;
            SET_MIN: state_d = SET_SEC;
            SET_SEC: state_d = SET_HR;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      set_time_d = (state_d != RUN);
      pulse_d    = '0;
      blink_d    = blink_q + 1'b1;
      case (state_d)
         SET_HR:  field_d = FIELD_HR;
         SET_MIN: field_d = FIELD_MIN;
         SET_SEC: field_d = FIELD_SEC;
         default: field_d = FIELD_NONE;
      endcase
      if ((state_q != RUN) && (state_d == state_q)) begin
         case (state_q)
            SET_HR: begin
               pulse_d[P_HOUR10] = inc_tens;
               pulse_d[P_HOUR1]  = inc_ones & ~inc_tens;
            end
            SET_MIN: begin
               pulse_d[P_MIN10] = inc_tens;
               pulse_d[P_MIN1]  = inc_ones & ~inc_tens;
            end
            default: begin
               pulse_d[P_SEC10] = inc_tens;
               pulse_d[P_SEC1]  = inc_ones & ~inc_tens;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         set_time_q <= 1'b0;
         field_q    <= FIELD_NONE;
         pulse_q    <= '0;
         blink_q    <= '0;
      end else begin
         set_time_q <= set_time_d;
         field_q    <= field_d;
         pulse_q    <= pulse_d;
         blink_q    <= blink_d;
      end
   end

   assign set_time = set_time_q;
   assign field    = field_q;
   assign hour10   = pulse_q[P_HOUR10];
   assign hour1    = pulse_q[P_HOUR1];
   assign min10    = pulse_q[P_MIN10];
   assign min1     = pulse_q[P_MIN1];
   assign sec10    = pulse_q[P_SEC10];
   assign sec1     = pulse_q[P_SEC1];
   assign blink    = set_time_q & blink_q[BLINK_BIT];

endmodule

`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_time_set_ctrl                                                      |
// | Directed self-checking bench for time_set_ctrl (AUTOREPEAT_EN aware). |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_mode = 1'b0, btn_next = 1'b0, btn_tens = 1'b0, btn_ones = 1'b0;
   logic       set_time, hour10, hour1, min10, min1, sec10, sec1, blink;
   logic [1:0] field;
   logic [5:0] pulses;

   int n_checks = 0;
   int n_fail   = 0;
   int pc[6];
   int base[6];
   int multi_hot = 0;

   localparam int I_SEC1 = 0, I_SEC10 = 1, I_MIN1 = 2, I_MIN10 = 3, I_HOUR1 = 4, I_HOUR10 = 5;

   time_set_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .BLINK_BIT       (3),
      .REPEAT_DELAY    (20),
      .REPEAT_RATE     (5)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_mode (btn_mode),
      .btn_next (btn_next),
      .btn_tens (btn_tens),
      .btn_ones (btn_ones),
      .set_time (set_time),
      .hour10   (hour10),
      .hour1    (hour1),
      .min10    (min10),
      .min1     (min1),
      .sec10    (sec10),
      .sec1     (sec1),
      .field    (field),
      .blink    (blink)
   );

   always #5 clk = ~clk;

   assign pulses = {hour10, hour1, min10, min1, sec10, sec1};

   initial for (int i = 0; i < 6; i++) pc[i] = 0;

   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < 6; i++) pc[i] += int'(pulses[i]);
         if ($countones(pulses) > 1) multi_hot++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      for (int i = 0; i < 6; i++) base[i] = pc[i];
   endtask

   // exp_idx = -1 means no pulse expected on any line
   task automatic chk_pulses(input string tag, input int exp_idx);
      for (int i = 0; i < 6; i++)
         chk($sformatf("%s_p%0d", tag, i), pc[i] - base[i], (i == exp_idx) ? 1 : 0);
   endtask

   task automatic chk_blink(input string tag, input int exp_highs);
      int highs = 0;
      for (int i = 0; i < 16; i++) begin
         highs += int'(blink);
         tick(1);
      end
      chk(tag, highs, exp_highs);
   endtask

   initial begin
      // Reset state
      tick(3);
      chk("rst_set_time", int'(set_time), 0);
      chk("rst_field", int'(field), 0);
      chk("rst_pulses", int'(pulses), 0);
      chk("rst_blink", int'(blink), 0);
      reset = 1'b1;
      tick(3);

      // Enter set mode, then reset mid-debounce of a pending ones press
      btn_mode = 1'b1; tick(8); btn_mode = 1'b0; tick(10);
      chk("pre_rst_set_time", int'(set_time), 1);
      snap();
      btn_ones = 1'b1; tick(4);
      reset = 1'b0; #2;
      chk("async_rst_set_time", int'(set_time), 0);
      chk("async_rst_field", int'(field), 0);
      tick(2); btn_ones = 1'b0; tick(1);
      reset = 1'b1; tick(12);
      chk("post_rst_set_time", int'(set_time), 0);
      chk_pulses("rst_discard", -1);
      chk_blink("blink_run", 0);

      // Tens press in RUN: no pulse
      snap();
      btn_tens = 1'b1; tick(8); btn_tens = 1'b0; tick(12);
      chk_pulses("run_tens", -1);
      chk("run_tens_set_time", int'(set_time), 0);

      // Mode press: set_time 6 cycles after raw edge
      btn_mode = 1'b1;
      tick(5);
      chk("mode_lat5_set_time", int'(set_time), 0);
      tick(1);
      chk("mode_lat6_set_time", int'(set_time), 1);
      chk("mode_lat6_field", int'(field), 1);
      tick(4); btn_mode = 1'b0; tick(12);
      chk("mode_release_field", int'(field), 1);
      chk_blink("blink_set", 8);

      // Ones press in SET_HR: single hour1 pulse, 1 cycle wide
      snap();
      btn_ones = 1'b1;
      tick(6);
      chk("hour1_edge", int'(hour1), 1);
      tick(1);
      chk("hour1_width", int'(hour1), 0);
      tick(1); btn_ones = 1'b0; tick(12);
      chk_pulses("hr_ones", I_HOUR1);

      // next, next -> seconds; tens -> sec10; next -> hours
      btn_next = 1'b1; tick(8); btn_next = 1'b0; tick(12);
      chk("next1_field", int'(field), 2);
      btn_next = 1'b1; tick(8); btn_next = 1'b0; tick(12);
      chk("next2_field", int'(field), 3);
      snap();
      btn_tens = 1'b1; tick(8); btn_tens = 1'b0; tick(12);
      chk_pulses("sec_tens", I_SEC10);
      btn_next = 1'b1; tick(8); btn_next = 1'b0; tick(12);
      chk("next3_field", int'(field), 1);

      // Bounced tens: high 3, low 1, high 3, low
      snap();
      btn_tens = 1'b1; tick(3); btn_tens = 1'b0; tick(1);
      btn_tens = 1'b1; tick(3); btn_tens = 1'b0; tick(12);
      chk_pulses("bounce", -1);
      chk("bounce_field", int'(field), 1);

      // SET_MIN, then mode and tens together: mode wins
      btn_next = 1'b1; tick(8); btn_next = 1'b0; tick(12);
      chk("min_field", int'(field), 2);
      snap();
      btn_mode = 1'b1; btn_tens = 1'b1; tick(8);
      btn_mode = 1'b0; btn_tens = 1'b0; tick(12);
      chk("coinc_set_time", int'(set_time), 0);
      chk("coinc_field", int'(field), 0);
      chk_pulses("coinc", -1);

      // Hold ones in SET_MIN
      btn_mode = 1'b1; tick(8); btn_mode = 1'b0; tick(12);
      btn_next = 1'b1; tick(8); btn_next = 1'b0; tick(12);
      chk("hold_field", int'(field), 2);
      snap();
      btn_ones = 1'b1; tick(36); btn_ones = 1'b0; tick(40);
`ifdef AUTOREPEAT_EN
      chk("hold_min1_count", pc[I_MIN1] - base[I_MIN1], 5);
`else
      chk("hold_min1_count", pc[I_MIN1] - base[I_MIN1], 1);
`endif
      chk("hold_min10_count", pc[I_MIN10] - base[I_MIN10], 0);
      chk("hold_field_after", int'(field), 2);

      chk("one_hot", multi_hot, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
